// File: rtl/spi_pkg.sv
// Shared definitions for the byte-level SPI controller.
//   spi_master_state_t : controller FSM states
//   SPI_BITS           : bits per transfer
//   max3()             : constant helper for sizing the phase counter
package spi_pkg;

    localparam int unsigned SPI_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StGap
    } spi_master_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/spi_master_byte.sv
// SPI mode-0 (CPOL=0, CPHA=0) byte controller running entirely on sys_clk.
// SCLK is produced by counting sys_clk; CS_N may be held low across bytes.
//   sys_clk   : system clock
//   reset     : synchronous, active-high
//   start     : request a byte, accepted when start && ready
//   tx_data   : byte to send, captured on accept
//   cs_hold   : captured on accept, 1 keeps CS_N low after the byte
//   end_frame : in HOLD, release CS_N without sending another byte
//   ready     : controller can accept start (IDLE or HOLD)
//   rx_data   : last received byte, updated with rx_valid
//   rx_valid  : one-cycle pulse when a byte completes
//   spi_cs_n  : chip select, active low
//   spi_sclk  : serial clock, idles low
//   spi_tx    : controller-out data, MSB first, 0 while CS_N high
//   spi_rx    : controller-in data, asynchronous
module spi_master_byte
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                cs_hold,
    input  logic                end_frame,
    output logic                ready,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                spi_cs_n,
    output logic                spi_sclk,
    output logic                spi_tx,
    input  logic                spi_rx
);

    localparam int unsigned CNT_MAX = max3(CLK_DIV, CS_SETUP, CS_GAP);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(SPI_BITS);

    // Counters hold "cycles remaining minus one" so terminal count is zero.
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(SPI_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

    if (CLK_DIV < 3) begin : g_chk_div
        $error("CLK_DIV must be >= 3 to leave margin for the spi_rx synchronizer");
    end
    if (CS_SETUP < 1) begin : g_chk_setup
        $error("CS_SETUP must be >= 1");
    end
    if (CS_GAP < 1) begin : g_chk_gap
        $error("CS_GAP must be >= 1");
    end

    spi_master_state_t   state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                hold_q, hold_d;
    logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_BITS-2:0] rx_shift_q, rx_shift_d;
    logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                rx_sync;
    logic                cnt_last;

    sync2 u_rx_sync (
        .clk   (sys_clk),
        .reset (reset),
        .d     (spi_rx),
        .q     (rx_sync)
    );

    assign cnt_last = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        hold_d     = hold_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StSetup;
                    cnt_d      = SETUP_LOAD;
                    bit_d      = BIT_FIRST;
                    hold_d     = cs_hold;
                    tx_shift_d = tx_data;
                end
            end
            StHold: begin
                // CS_N is already low, so the lead-in is one SCLK half-period
                // rather than the CS setup time. start beats end_frame.
                if (start) begin
                    state_d    = StSetup;
                    cnt_d      = DIV_LOAD;
                    bit_d      = BIT_FIRST;
                    hold_d     = cs_hold;
                    tx_shift_d = tx_data;
                end else if (end_frame) begin
                    state_d = StGap;
                    cnt_d   = GAP_LOAD;
                end
            end
            StSetup: begin
                if (cnt_last) begin
                    state_d = StHigh;
                    cnt_d   = DIV_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StHigh: begin
                if (cnt_last) begin
                    // Last sys_clk of the high phase: sample MISO, advance MOSI
                    // so it changes together with the falling SCLK.
                    state_d    = StLow;
                    cnt_d      = DIV_LOAD;
                    rx_shift_d = {rx_shift_q[SPI_BITS-3:0], rx_sync};
                    tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
                    if (bit_q == '0) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {rx_shift_q, rx_sync};
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StLow: begin
                if (cnt_last) begin
                    if (bit_q == '0) begin
                        if (hold_q) begin
                            state_d = StHold;
                        end else begin
                            state_d = StGap;
                            cnt_d   = GAP_LOAD;
                        end
                    end else begin
                        state_d = StHigh;
                        cnt_d   = DIV_LOAD;
                        bit_d   = bit_q - BIT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StGap: begin
                if (cnt_last) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pin values are decoded from the next state and registered, so the
        // SPI pins and ready change on the same edge as the state.
        cs_n_d  = (state_d == StIdle) || (state_d == StGap);
        sclk_d  = (state_d == StHigh);
        ready_d = (state_d == StIdle) || (state_d == StHold);
        tx_d    = !cs_n_d && tx_shift_d[SPI_BITS-1];
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            hold_q     <= 1'b0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            tx_q       <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            hold_q     <= hold_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_cs_n = cs_n_q;
    assign spi_sclk = sclk_q;
    assign spi_tx   = tx_q;

endmodule
